// File: rtl/cayde_alu_issue.sv
// RV32I ALU decode-and-issue stage with pending-register scoreboard and a registered ALU slot.
// Define CAYDE_ISSUE_BYPASS_EN to let a same-cycle writeback unblock and forward into a source.
package cayde_pkg;
    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_XOR = 3'd2,
        ALU_OR  = 3'd3,
        ALU_AND = 3'd4,
        ALU_NOT = 3'd5
    } alu_op;
endpackage

module cayde_alu_issue (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  logic [31:0]         instr_i,
    output logic [4:0]          rs1_addr_o,
    output logic [4:0]          rs2_addr_o,
    input  logic [31:0]         rs1_data_i,
    input  logic [31:0]         rs2_data_i,
    output logic                alu_valid_o,
    input  logic                alu_ready_i,
    output cayde_pkg::alu_op    alu_op_o,
    output logic [31:0]         alu_a_o,
    output logic [31:0]         alu_b_o,
    output logic [4:0]          alu_rd_o,
    input  logic                wb_valid_i,
    input  logic [4:0]          wb_rd_i,
    input  logic [31:0]         wb_data_i,
    output logic                illegal_o
);
    import cayde_pkg::*;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [31:0] imm;

    logic        dec_legal;
    logic        dec_is_r;
    alu_op       dec_op;

    logic [31:0] pending_q, pending_d;
    logic        valid_q, valid_d;
    alu_op       op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [4:0]  rd_q, rd_d;
    logic        illegal_q, illegal_d;

    logic        fwd1, fwd2;
    logic        blk1, blk2;
    logic        hazard;
    logic        slot_free;
    logic        accept;
    logic [31:0] op_a, op_b;

    assign opcode     = instr_i[6:0];
    assign rd         = instr_i[11:7];
    assign funct3     = instr_i[14:12];
    assign rs1_addr_o = instr_i[19:15];
    assign rs2_addr_o = instr_i[24:20];
    assign funct7     = instr_i[31:25];
    assign imm        = {{20{instr_i[31]}}, instr_i[31:20]};

    always_comb begin
        dec_legal = 1'b0;
        dec_is_r  = 1'b0;
        dec_op    = ALU_ADD;
        unique case (opcode)
            7'b0110011: begin
                dec_is_r = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_ADD;
                        end else if (funct7 == 7'b0100000) begin
                            dec_legal = 1'b1;
                            dec_op    = ALU_SUB;
                        end
                    end
                    3'b100: begin dec_legal = (funct7 == 7'b0000000); dec_op = ALU_XOR; end
                    3'b110: begin dec_legal = (funct7 == 7'b0000000); dec_op = ALU_OR;  end
                    3'b111: begin dec_legal = (funct7 == 7'b0000000); dec_op = ALU_AND; end
                    default: ;
                endcase
            end
            7'b0010011: begin
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_op = ALU_ADD; end
                    3'b100: begin dec_legal = 1'b1; dec_op = ALU_XOR; end
                    3'b110: begin dec_legal = 1'b1; dec_op = ALU_OR;  end
                    3'b111: begin dec_legal = 1'b1; dec_op = ALU_AND; end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

`ifdef CAYDE_ISSUE_BYPASS_EN
    assign fwd1 = wb_valid_i && (wb_rd_i == rs1_addr_o) && pending_q[rs1_addr_o];
    assign fwd2 = wb_valid_i && (wb_rd_i == rs2_addr_o) && pending_q[rs2_addr_o];
`else
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign blk1      = pending_q[rs1_addr_o] && !fwd1;
    assign blk2      = pending_q[rs2_addr_o] && !fwd2;
    assign hazard    = dec_legal && (blk1 || (dec_is_r && blk2));
    assign slot_free = !valid_q || alu_ready_i;
    assign instr_ready_o = slot_free && !hazard;
    assign accept    = instr_valid_i && instr_ready_o;
    assign op_a      = fwd1 ? wb_data_i : rs1_data_i;
    assign op_b      = fwd2 ? wb_data_i : rs2_data_i;

    always_comb begin
        valid_d   = valid_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        rd_d      = rd_q;
        illegal_d = accept && !dec_legal;
        pending_d = pending_q;
        if (valid_q && alu_ready_i)
            valid_d = 1'b0;
        if (accept && dec_legal) begin
            valid_d = 1'b1;
            op_d    = dec_op;
            a_d     = op_a;
            b_d     = dec_is_r ? op_b : imm;
            rd_d    = rd;
        end
        // Clear before set so a same-index set wins.
        if (wb_valid_i)
            pending_d[wb_rd_i] = 1'b0;
        if (accept && dec_legal)
            pending_d[rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            valid_q   <= 1'b0;
            op_q      <= ALU_ADD;
            a_q       <= '0;
            b_q       <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            pending_q <= '0;
        end else begin
            valid_q   <= valid_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
            pending_q <= pending_d;
        end
    end

    assign alu_valid_o = valid_q;
    assign alu_op_o    = op_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_rd_o    = rd_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_cayde_alu_issue.sv
// Directed bench for cayde_alu_issue; expected issue records are queued at drive time and checked after the edge.
module tb_cayde_alu_issue;
    import cayde_pkg::*;

    typedef struct packed {
        alu_op       op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            instr_valid;
    logic            instr_ready;
    logic [31:0]     instr;
    logic [4:0]      rs1_addr, rs2_addr;
    logic [31:0]     rs1_data, rs2_data;
    logic            alu_valid;
    logic            alu_ready;
    alu_op           alu_op_s;
    logic [31:0]     alu_a, alu_b;
    logic [4:0]      alu_rd;
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [31:0]     wb_data;
    logic            illegal;

    logic [31:0]     rf [32];
    exp_t            sb [$];
    int              n_assert = 0;
    int              n_fail   = 0;

    always #5 clk = ~clk;

    assign rs1_data = rf[rs1_addr];
    assign rs2_data = rf[rs2_addr];

    cayde_alu_issue dut (
        .clk_i(clk), .rst_ni(rst_n),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_i(instr),
        .rs1_addr_o(rs1_addr), .rs2_addr_o(rs2_addr),
        .rs1_data_i(rs1_data), .rs2_data_i(rs2_data),
        .alu_valid_o(alu_valid), .alu_ready_i(alu_ready), .alu_op_o(alu_op_s),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_rd_o(alu_rd),
        .wb_valid_i(wb_valid), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .illegal_o(illegal)
    );

    function automatic logic [31:0] enc_i(logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [2:0] f3, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input alu_op op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        e.op = op; e.a = a; e.b = b; e.rd = rd;
        sb.push_back(e);
    endtask

    task automatic send(input logic [31:0] w, input logic exp_rdy, input string tag);
        instr       = w;
        instr_valid = 1'b1;
        #1;
        chk(tag, {31'd0, instr_ready}, {31'd0, exp_rdy});
    endtask

    // Advance one edge; the bench register file absorbs writebacks, then any queued issue is checked.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (wb_valid && wb_rd != 5'd0)
            rf[wb_rd] = wb_data;
        instr_valid = 1'b0;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("issue_valid", {31'd0, alu_valid}, 32'd1);
            chk("issue_op", 32'(alu_op_s), 32'(e.op));
            chk("issue_a", alu_a, e.a);
            chk("issue_b", alu_b, e.b);
            chk("issue_rd", {27'd0, alu_rd}, {27'd0, e.rd});
        end
    endtask

    initial begin
        rf[0] = '0;
        for (int i = 1; i < 32; i++) rf[i] = 32'hA000_0000 + 32'(i);
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; alu_ready = 1'b1;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        #2;
        step(); step();
        chk("rst_valid",   {31'd0, alu_valid}, 32'd0);
        chk("rst_op",      32'(alu_op_s), 32'(ALU_ADD));
        chk("rst_a",       alu_a, 32'd0);
        chk("rst_b",       alu_b, 32'd0);
        chk("rst_rd",      {27'd0, alu_rd}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        rst_n = 1'b1;

        send(enc_i(3'b000, 5'd1, 5'd0, 12'd5), 1'b1, "rdy_addi_x1");
        push(ALU_ADD, 32'd0, 32'd5, 5'd1); step();
        send(enc_i(3'b000, 5'd2, 5'd0, 12'hFFF), 1'b1, "rdy_addi_x2");
        push(ALU_ADD, 32'd0, 32'hFFFF_FFFF, 5'd2); step();
        send(enc_i(3'b000, 5'd3, 5'd1, 12'd1), 1'b0, "rdy_raw_x1");
        step();
        chk("drain_empty", {31'd0, alu_valid}, 32'd0);

        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'd5; step();
        wb_rd = 5'd2; wb_data = 32'hFFFF_FFFF; step();
        wb_valid = 1'b0;

        send(enc_r(7'b0100000, 3'b000, 5'd3, 5'd1, 5'd2), 1'b1, "rdy_sub");
        push(ALU_SUB, 32'd5, 32'hFFFF_FFFF, 5'd3); step();
        send(enc_i(3'b110, 5'd6, 5'd1, 12'h0F0), 1'b1, "rdy_ori");
        push(ALU_OR, 32'd5, 32'h0000_00F0, 5'd6); step();
        send(enc_i(3'b111, 5'd7, 5'd2, 12'h800), 1'b1, "rdy_andi");
        push(ALU_AND, 32'hFFFF_FFFF, 32'hFFFF_F800, 5'd7); step();
        send(enc_r(7'b0000001, 3'b000, 5'd8, 5'd1, 5'd2), 1'b1, "rdy_bad_f7");
        step();
        chk("bad_f7_illegal", {31'd0, illegal}, 32'd1);
        chk("bad_f7_novalid", {31'd0, alu_valid}, 32'd0);
        step();
        chk("bad_f7_pulse_end", {31'd0, illegal}, 32'd0);

        send(enc_r(7'b0000000, 3'b000, 5'd4, 5'd1, 5'd2), 1'b1, "rdy_add_x4");
        push(ALU_ADD, 32'd5, 32'hFFFF_FFFF, 5'd4); step();
        send(enc_r(7'b0000000, 3'b100, 5'd5, 5'd4, 5'd1), 1'b0, "rdy_raw_x4_a");
        step();
        chk("raw_bubble", {31'd0, alu_valid}, 32'd0);
        send(enc_r(7'b0000000, 3'b100, 5'd5, 5'd4, 5'd1), 1'b0, "rdy_raw_x4_b");
        step();
        wb_valid = 1'b1; wb_rd = 5'd4; wb_data = 32'h1234_5678;
`ifdef CAYDE_ISSUE_BYPASS_EN
        send(enc_r(7'b0000000, 3'b100, 5'd5, 5'd4, 5'd1), 1'b1, "rdy_wb_bypass");
        push(ALU_XOR, 32'h1234_5678, 32'd5, 5'd5); step();
        wb_valid = 1'b0;
`else
        send(enc_r(7'b0000000, 3'b100, 5'd5, 5'd4, 5'd1), 1'b0, "rdy_wb_same_cycle");
        step();
        wb_valid = 1'b0;
        send(enc_r(7'b0000000, 3'b100, 5'd5, 5'd4, 5'd1), 1'b1, "rdy_after_wb");
        push(ALU_XOR, 32'h1234_5678, 32'd5, 5'd5); step();
`endif

        alu_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            send(enc_i(3'b000, 5'd8, 5'd0, 12'd7), 1'b0, "rdy_stall");
            step();
            chk("stall_valid", {31'd0, alu_valid}, 32'd1);
            chk("stall_op",    32'(alu_op_s), 32'(ALU_XOR));
            chk("stall_a",     alu_a, 32'h1234_5678);
            chk("stall_rd",    {27'd0, alu_rd}, 32'd5);
        end
        alu_ready = 1'b1;
        send(enc_i(3'b000, 5'd8, 5'd0, 12'd7), 1'b1, "rdy_swap");
        push(ALU_ADD, 32'd0, 32'd7, 5'd8); step();

        send(32'h0000_0073, 1'b1, "rdy_ecall");
        step();
        chk("ecall_illegal", {31'd0, illegal}, 32'd1);
        chk("ecall_novalid", {31'd0, alu_valid}, 32'd0);
        step();
        chk("ecall_pulse_end", {31'd0, illegal}, 32'd0);
        send(enc_i(3'b000, 5'd9, 5'd8, 12'd1), 1'b0, "rdy_pending_kept");
        step();

        alu_ready = 1'b0;
        send(enc_r(7'b0000000, 3'b000, 5'd4, 5'd0, 5'd0), 1'b1, "rdy_add_x4_again");
        push(ALU_ADD, 32'd0, 32'd0, 5'd4); step();
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("midrst_valid",   {31'd0, alu_valid}, 32'd0);
        chk("midrst_illegal", {31'd0, illegal}, 32'd0);
        alu_ready = 1'b1;
        send(enc_r(7'b0000000, 3'b100, 5'd5, 5'd4, 5'd0), 1'b1, "rdy_after_rst");
        push(ALU_XOR, 32'h1234_5678, 32'd0, 5'd5); step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
